// File: rtl/sram_req_gate_if.sv
// OBI A-channel plus response bundle used on both the core side and the SRAM side of sram_req_gate.
// The manager drives the request fields; the subordinate returns grant and response.
interface sram_req_gate_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, err, rdata
    );
endinterface

// File: rtl/sram_req_gate.sv
// Single-outstanding OBI gate: looks up the block slot through req_blocker_ctrl, holds the
// request while the block is unavailable, then issues it to the SRAM at the translated address.
module sram_req_gate #(
    parameter logic [31:0] SramBaseAddr = 32'h1000_0000,
    parameter int unsigned BlockOffW    = 9,
    parameter int unsigned NumSlots     = 4,
    localparam int unsigned IdxW        = $clog2(NumSlots)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                swap_en_i,
    sram_req_gate_if.slave      core,
    sram_req_gate_if.master     sram,
    output logic [20:0]         req_addr_o,
    output logic                valid_o,
    input  logic                block_i,
    input  logic [IdxW-1:0]     sram_addr_idx_i,
    input  logic                clr_stats_i,
    output logic [15:0]         stall_cycles_o
);

    typedef enum logic [2:0] {IDLE, LOOKUP, STALL, ISSUE, RESP} state_e;

    localparam logic [31:0] OffMask = (32'd1 << BlockOffW) - 32'd1;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] sram_addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        rvalid_q;
    logic [15:0] stall_q;

    function automatic logic [31:0] xlate(input logic [31:0] addr, input logic [IdxW-1:0] idx);
        logic [31:0] slot_base;
        slot_base = 32'(idx) << BlockOffW;
        return SramBaseAddr + slot_base + (addr & OffMask);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // RESP stays put through the rvalid pulse so a new grant cannot overlap it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          if (core.req) state_d = swap_en_i ? LOOKUP : ISSUE;
            LOOKUP, STALL: state_d = block_i ? STALL : ISSUE;
            ISSUE:         if (sram.gnt) state_d = RESP;
            RESP:          if (rvalid_q) state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    always_comb begin
        core.gnt = 1'b0;
        valid_o  = 1'b0;
        sram.req = 1'b0;
        case (state_q)
            IDLE:          core.gnt = 1'b1;
            LOOKUP, STALL: valid_o  = 1'b1;
            ISSUE:         sram.req = 1'b1;
            default:       ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            sram_addr_q <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            stall_q     <= '0;
        end else begin
            rvalid_q <= (state_q == RESP) && !rvalid_q && sram.rvalid;
            case (state_q)
                IDLE: if (core.req) begin
                    addr_q      <= core.addr;
                    sram_addr_q <= core.addr;
                    we_q        <= core.we;
                    be_q        <= core.be;
                    wdata_q     <= core.wdata;
                end
                LOOKUP, STALL: if (!block_i) sram_addr_q <= xlate(addr_q, sram_addr_idx_i);
                RESP: if (!rvalid_q && sram.rvalid) begin
                    rdata_q <= sram.rdata;
                    err_q   <= sram.err;
                end
                default: ;
            endcase
            if (clr_stats_i)            stall_q <= '0;
            else if (state_q == STALL)  stall_q <= sat_inc(stall_q);
        end
    end

    assign sram.addr      = sram_addr_q;
    assign sram.we        = we_q;
    assign sram.be        = be_q;
    assign sram.wdata     = wdata_q;
    assign core.rvalid    = rvalid_q;
    assign core.rdata     = rdata_q;
    assign core.err       = err_q;
    assign req_addr_o     = addr_q[BlockOffW +: 21];
    assign stall_cycles_o = stall_q;

endmodule
